// File: rtl/dmi_scan_register.sv
// dmi_scan_register
// -----------------
// JTAG-side Debug Module Interface data register. It lives entirely in the
// tck domain and turns a completed Shift-DR scan into a single outstanding
// read/write request toward the debug module. The response is kept so the
// next scan can shift it out. Busy and sticky error status follow the RISC-V
// DTM convention.
//
// Scan register layout, W = ABITS + DATA_W + 2, LSB first:
//   op[1:0], data[DATA_W+1:2], addr[W-1:DATA_W+2]
//
// Ports
//   tck, reset             : clock and synchronous active-high reset
//   tdi, tdo               : scan in / scan out (tdo = sr[0])
//   select                 : IR selects DMI; all strobes are ignored without it
//   captureDR/shiftDR/updateDR : TAP strobes (capture > shift > update)
//   dmi_reset              : clears the sticky error, beats any same-cycle set
//   req_valid/ready, req_addr/data/op : request channel (op 1 = read, 2 = write)
//   rsp_valid/ready, rsp_data/op      : response channel (op 0 ok, 2 failed, 3 busy)
//   busy                   : a transaction is outstanding
//   sticky_err             : 0 none, 2 failed, 3 busy
//
// Optional build macro
//   DMI_TIMEOUT_EN : abandon a transaction that sits in REQ/RSP for TIMEOUT
//                    tck cycles and flag it as failed. Without the macro the
//                    block waits indefinitely and TIMEOUT is unused.

module dmi_scan_register #(
  parameter int unsigned ABITS   = 7,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              tck,
  input  logic              reset,
  input  logic              tdi,
  input  logic              select,
  input  logic              captureDR,
  input  logic              shiftDR,
  input  logic              updateDR,
  input  logic              dmi_reset,
  output logic              tdo,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ABITS-1:0]  req_addr,
  output logic [DATA_W-1:0] req_data,
  output logic [1:0]        req_op,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic [1:0]        rsp_op,
  output logic              busy,
  output logic [1:0]        sticky_err
);

  localparam int unsigned W = ABITS + DATA_W + 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;

  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_FAILED = 2'd2;
  localparam logic [1:0] ST_BUSY   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [W-1:0]      sr_q, sr_d;
  logic [1:0]        sticky_q, sticky_d;
  logic [ABITS-1:0]  req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic [1:0]        req_op_q, req_op_d;
  logic [DATA_W-1:0] rsp_latch_q, rsp_latch_d;
  logic [ABITS-1:0]  last_addr_q, last_addr_d;

  logic       busy_s;
  logic [1:0] status_s;
  logic [1:0] sr_op_s;
  logic       start_s;
  logic       cap_busy_s;
  logic       upd_busy_s;
  logic       rsp_fire_s;
  logic [1:0] fsm_next_s;
  logic       timeout_s;

  assign busy_s  = (state_q != IDLE);
  assign sr_op_s = sr_q[1:0];

  // Status shifted out on capture: an existing sticky error dominates, otherwise report busy.
  always_comb begin
    if (sticky_q != ST_OK) begin
      status_s = sticky_q;
    end else if (busy_s) begin
      status_s = ST_BUSY;
    end else begin
      status_s = ST_OK;
    end
  end

  // Scan strobes, request launch and FSM successor; everything is decoded on start-of-cycle state.
  always_comb begin
    sr_d        = sr_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_op_d    = req_op_q;
    rsp_latch_d = rsp_latch_q;
    last_addr_d = last_addr_q;
    start_s     = 1'b0;
    cap_busy_s  = 1'b0;
    upd_busy_s  = 1'b0;
    rsp_fire_s  = 1'b0;
    fsm_next_s  = state_q;

    if (select && captureDR) begin
      sr_d       = {last_addr_q, rsp_latch_q, status_s};
      cap_busy_s = busy_s;
    end else if (select && shiftDR) begin
      sr_d = {tdi, sr_q[W-1:1]};
    end else if (select && updateDR) begin
      // A pending sticky error blocks every update until dmi_reset.
      if (sticky_q != ST_OK) begin
        start_s = 1'b0;
      end else if (busy_s) begin
        upd_busy_s = 1'b1;
      end else if ((sr_op_s == OP_READ) || (sr_op_s == OP_WRITE)) begin
        start_s     = 1'b1;
        req_op_d    = sr_op_s;
        req_data_d  = sr_q[DATA_W+1:2];
        req_addr_d  = sr_q[W-1:DATA_W+2];
        last_addr_d = sr_q[W-1:DATA_W+2];
      end else begin
        start_s = 1'b0;
      end
    end else begin
      sr_d = sr_q;
    end

    case (state_q)
      IDLE: begin
        if (start_s) begin
          fsm_next_s = REQ;
        end else begin
          fsm_next_s = IDLE;
        end
      end
      REQ: begin
        if (req_ready) begin
          fsm_next_s = RSP;
        end else begin
          fsm_next_s = REQ;
        end
      end
      RSP: begin
        // Response data is kept for writes as well as reads.
        if (rsp_valid) begin
          rsp_fire_s  = 1'b1;
          rsp_latch_d = rsp_data;
          fsm_next_s  = IDLE;
        end else begin
          fsm_next_s = RSP;
        end
      end
      default: begin
        fsm_next_s = IDLE;
      end
    endcase
  end

`ifdef DMI_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Cycles spent in the current REQ/RSP state; fires on the TIMEOUT-th cycle without progress.
  always_comb begin
    timeout_s = 1'b0;
    cnt_d     = {CNT_W{1'b0}};
    if (busy_s && (fsm_next_s == state_q)) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        timeout_s = 1'b1;
      end else begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Timeout counter register.
  always_ff @(posedge tck) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Final state and sticky error; dmi_reset beats every sticky source in the same cycle.
  always_comb begin
    if (timeout_s) begin
      state_d = IDLE;
    end else begin
      state_d = fsm_next_s;
    end

    if (dmi_reset) begin
      sticky_d = ST_OK;
    end else if (timeout_s) begin
      sticky_d = ST_FAILED;
    end else if (rsp_fire_s && (rsp_op != ST_OK)) begin
      sticky_d = rsp_op;
    end else if (cap_busy_s || upd_busy_s) begin
      sticky_d = ST_BUSY;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // State registers.
  always_ff @(posedge tck) begin
    if (reset) begin
      state_q     <= IDLE;
      sr_q        <= {W{1'b0}};
      sticky_q    <= ST_OK;
      req_addr_q  <= {ABITS{1'b0}};
      req_data_q  <= {DATA_W{1'b0}};
      req_op_q    <= 2'd0;
      rsp_latch_q <= {DATA_W{1'b0}};
      last_addr_q <= {ABITS{1'b0}};
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      sticky_q    <= sticky_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_op_q    <= req_op_d;
      rsp_latch_q <= rsp_latch_d;
      last_addr_q <= last_addr_d;
    end
  end

  assign tdo        = sr_q[0];
  assign req_valid  = (state_q == REQ);
  assign rsp_ready  = (state_q == RSP);
  assign busy       = busy_s;
  assign sticky_err = sticky_q;
  assign req_addr   = req_addr_q;
  assign req_data   = req_data_q;
  assign req_op     = req_op_q;

endmodule
